fc2_argmax: RTL

FC2_ARGMAX -- requirements
Module: fc2_argmax

---
 rtl/fc2_argmax.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fc2_argmax.sv
// Output layer of a 128->10 classifier: ten signed dot products against ROM weights
// plus a scaled bias, reduced to the index and value of the largest score.
module fc2_argmax #(
    parameter logic [10:0] rom_addr_base  = 11'h410,
    parameter logic [10:0] bias_addr_base = 11'h460
) (
    input  logic          clk,
    input  logic          iRst,
    input  logic          ena,
    input  logic          start,
    input  logic [1023:0] data_from_fc1,
    input  logic [127:0]  data_from_rom,
    output logic [10:0]   addr_to_rom,
    output logic          busy,
    output logic          done,
    output logic [3:0]    digit,
    output logic [23:0]   max_score
);

    typedef enum logic [2:0] {IDLE, BREQ, BGET, MREQ, MACC, FIN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [3:0]         n_reg, n_next;
    logic [2:0]         c_reg, c_next;
    logic [10:0]        addr_reg, addr_next;
    logic               accept;

    logic [1023:0]      act_reg;
    logic signed [7:0]  bias_reg [10];
    logic signed [23:0] acc_reg;
    logic               busy_reg, done_reg;
    logic [3:0]         digit_reg;
    logic signed [23:0] max_reg;

    logic [127:0]       act_row;
    logic signed [16:0] prod [16];
    logic signed [23:0] row_sum, fin_sum;
    logic signed [7:0]  bias_cur;

    // Column c of the weight matrix pairs with activations 16c..16c+15.
    assign act_row = act_reg[{c_reg, 7'b0} +: 128];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_mul
            logic signed [16:0] w_ext, a_ext;
            assign w_ext    = {{9{data_from_rom[8*gi+7]}}, data_from_rom[8*gi +: 8]};
            assign a_ext    = {9'b0, act_row[8*gi +: 8]};
            assign prod[gi] = w_ext * a_ext;
        end
    endgenerate

    always_comb begin
        row_sum = '0;
        for (int k = 0; k < 16; k++) begin
            row_sum = row_sum + {{7{prod[k][16]}}, prod[k]};
        end
    end

    assign bias_cur = bias_reg[n_reg];
    assign fin_sum  = acc_reg + {{9{bias_cur[7]}}, bias_cur, 7'b0};

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        c_next     = c_reg;
        addr_next  = addr_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = BREQ;
                    n_next     = '0;
                    c_next     = '0;
                    addr_next  = bias_addr_base;
                end
            end
            BREQ: state_next = BGET;
            BGET: state_next = MREQ;
            MREQ: state_next = MACC;
            MACC: begin
                if (c_reg == 3'd7) begin
                    state_next = FIN;
                    c_next     = '0;
                end else begin
                    state_next = MREQ;
                    c_next     = c_reg + 3'd1;
                end
            end
            FIN: begin
                if (n_reg == 4'd9) begin
                    state_next = DONE;
                end else begin
                    state_next = MREQ;
                    n_next     = n_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        // The address is registered on entry to MREQ so the word arrives during MACC.
        if (state_next == MREQ && state_reg != MREQ) begin
            addr_next = rom_addr_base + {4'b0, n_next, c_next};
        end
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            c_reg     <= '0;
            addr_reg  <= '0;
        end else if (ena) begin
            state_reg <= state_next;
            n_reg     <= n_next;
            c_reg     <= c_next;
            addr_reg  <= addr_next;
        end
    end

    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            acc_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            digit_reg <= '0;
            max_reg   <= '0;
        end else if (ena) begin
            if (accept) begin
                acc_reg   <= '0;
                busy_reg  <= 1'b1;
                done_reg  <= 1'b0;
                digit_reg <= '0;
                max_reg   <= '0;
            end else if (state_reg == MACC) begin
                acc_reg <= acc_reg + row_sum;
            end else if (state_reg == FIN) begin
                acc_reg <= '0;
                // Strict compare keeps the lowest index on ties.
                if (n_reg == 4'd0 || fin_sum > max_reg) begin
                    max_reg   <= fin_sum;
                    digit_reg <= n_reg;
                end
                if (n_reg == 4'd9) begin
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ena) begin
            if (accept) begin
                act_reg <= data_from_fc1;
            end
            if (state_reg == BGET) begin
                for (int b = 0; b < 10; b++) begin
                    bias_reg[b] <= data_from_rom[8*b +: 8];
                end
            end
        end
    end

    assign addr_to_rom = addr_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign digit       = digit_reg;
    assign max_score   = max_reg;

endmodule
